fsic_coreclk_phase_tracker: RTL
===============================

# fsic_coreclk_phase_tracker

Parametrised ioclk-domain tracker that recovers the phase of coreclk within each coreclk period from a coreclk-generated toggle signal. It supports any integer clock ratio, configurable alignment offset and synchroniser depth, and adds lock acquisition plus period-error detection. It sits in io_serdes beside the TX/RX serialisers, which consume `phase_cnt` to select the lane slot.

## Interface
- `pCLK_RATIO`, 4: ioclk cycles per coreclk period; ≥2, need not be a power of 2.
- `pSYNC_STAGES`, 2: synchroniser flops on `core_clk_toggle`; ≥1.
- `pPHASE_OFFSET`, 0: value loaded into `phase_cnt` on a detected toggle edge; must be < `pCLK_RATIO`.
- `pLOCK_CNT`, 4: consecutive good periods required to declare lock; ≥1.
- `ioclk`  in  1  sole clock.
- `axis_rst`  in  1  asynchronous, active-high reset.
- `core_clk_toggle`  in  1  inverts on every coreclk rising edge; produced in the coreclk domain.
- `phase_cnt`  out  `$clog2(pCLK_RATIO)`  current phase, 0..`pCLK_RATIO`-1.
- `phase_last`  out  1  high when `phase_cnt == pCLK_RATIO-1`.
- `phase_lock`  out  1  high in the LOCKED state.
- `phase_err`  out  1  one-cycle pulse on a period error while LOCKED.

## Operation
- Synchroniser: `core_clk_toggle` passes through `pSYNC_STAGES` flops, followed by one history flop `prev`.
- Edge: `edge = sync_out ^ prev`.
- Phase counter:
  - on `edge`: load `pPHASE_OFFSET`;
  - otherwise: increment, wrapping from `pCLK_RATIO-1` to 0 (explicit compare, not power-of-2 overflow).
  - It always realigns on an edge, in every state.
- `phase_last` is registered alongside `phase_cnt`, so both change on the same edge.
- Interval counter (`$clog2(pCLK_RATIO+1)` bits):
  - cleared on `edge`;
  - otherwise incremented, saturating at `pCLK_RATIO`.
- Edge classification:
  - good edge: `edge` while interval == `pCLK_RATIO-1`;
  - bad edge: `edge` at any other interval value, including a late edge at saturation.
- Timeout: no `edge` while interval == `pCLK_RATIO-1`. This fires exactly once per gap, at the step into saturation. Once saturated, a subsequent edge is a bad edge, never a second timeout.
- FSM (UNLOCK, ACQ, LOCKED); `good_cnt` is `$clog2(pLOCK_CNT+1)` bits:
  - UNLOCK: any edge → ACQ with `good_cnt` = 0. Timeouts are ignored.
  - ACQ:
    - good edge → `good_cnt`+1; when `good_cnt == pLOCK_CNT-1` → LOCKED;
    - bad edge → stay in ACQ with `good_cnt` = 0;
    - timeout → UNLOCK.
  - LOCKED:
    - good edge → stay;
    - bad edge → ACQ with `good_cnt` = 0, and pulse `phase_err`;
    - timeout → UNLOCK, and pulse `phase_err`.
- `phase_err` pulses only for errors taken from LOCKED.

## Timing
- Reset values: `phase_cnt` = 0, `phase_last` = 0, `phase_lock` = 0, `phase_err` = 0. The synchroniser, `prev`, interval, `good_cnt` and FSM also reset to zero/UNLOCK.
- Latency: a toggle change before ioclk edge k gives `phase_cnt == pPHASE_OFFSET` after edge k+`pSYNC_STAGES`. This is `pSYNC_STAGES`+1 edges, counting edge k.
- Lock: `phase_lock` rises on the clock edge that accepts the `pLOCK_CNT`-th consecutive good edge. With `pLOCK_CNT` = 4, that is the 5th toggle edge after UNLOCK.
- `phase_lock` falls on the same edge that pulses `phase_err`.
- Reset mid-operation: all state clears immediately. If `core_clk_toggle` is 1 at reset release, a spurious first edge is detected; this is harmless because it only moves UNLOCK → ACQ.

## Configuration
- `FSIC_PHASE_TRK_ERR_CNT_EN` defined:
  - adds input `err_clr` (1 bit) and output `err_cnt` (16 bits);
  - `err_cnt` increments on each `phase_err` pulse and saturates at 16'hFFFF;
  - `err_clr` zeroes it synchronously, with priority over an increment in the same cycle;
  - `err_cnt` resets to 0.
- Not defined: both ports and the counter are absent; all other behaviour is identical.

## Structure
- Package `fsic_io_serdes_pkg`:
  - FSM state encodings (UNLOCK = 2'd0, ACQ = 2'd1, LOCKED = 2'd2);
  - the shared `err_cnt` width constant (16).
- Sub-module `fsic_bit_sync`: parametrised N-flop single-bit synchroniser (`pSTAGES`, resettable to 0). It is reused by other io_serdes blocks.

## Test plan
- Steady ratio, `pCLK_RATIO` = 4, offset 0, toggle every 4 cycles → `phase_cnt` reads 0,1,2,3 repeating; `phase_last` high on phase 3; `phase_lock` rises at the 5th edge; `phase_err` never pulses.
- `pCLK_RATIO` = 3, `pPHASE_OFFSET` = 2 → sequence 2,0,1 repeating, with no 3 ever appearing; lock is reached.
- Locked, then one toggle edge arrives 1 cycle early → `phase_err` pulses once; `phase_lock` drops; `phase_cnt` loads the offset at the early edge; lock returns after 4 further good periods.
- Locked, then toggling stops → exactly one `phase_err` pulse, 4 cycles after the last edge; state UNLOCK; `phase_cnt` keeps free-running mod 4.
- `axis_rst` asserted mid-period while LOCKED → all outputs read 0 immediately; after release, relock is reached in the same number of cycles as from power-up.
- With `FSIC_PHASE_TRK_ERR_CNT_EN`: 3 forced errors → `err_cnt` = 3; `err_clr` asserted in the same cycle as a 4th error → `err_cnt` = 0.

Source files
------------

// File: rtl/fsic_io_serdes_pkg.sv
// Shared io_serdes definitions: phase tracker FSM encodings and error counter width.
package fsic_io_serdes_pkg;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } phase_trk_state_e;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/fsic_bit_sync.sv
// Parametrised N-flop single-bit synchroniser, cleared to 0 on reset.
module fsic_bit_sync #(
    parameter int pSTAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [pSTAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < pSTAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[pSTAGES-1];

endmodule

// File: rtl/fsic_coreclk_phase_tracker.sv
// Recovers coreclk phase in the ioclk domain from a coreclk toggle, with lock tracking.
// Optional FSIC_PHASE_TRK_ERR_CNT_EN adds a saturating error counter (err_clr/err_cnt).
module fsic_coreclk_phase_tracker
    import fsic_io_serdes_pkg::*;
#(
    parameter int pCLK_RATIO    = 4,
    parameter int pSYNC_STAGES  = 2,
    parameter int pPHASE_OFFSET = 0,
    parameter int pLOCK_CNT     = 4
) (
    input  logic                          ioclk,
    input  logic                          axis_rst,
    input  logic                          core_clk_toggle,
`ifdef FSIC_PHASE_TRK_ERR_CNT_EN
    input  logic                          err_clr,
    output logic [ERR_CNT_W-1:0]          err_cnt,
`endif
    output logic [$clog2(pCLK_RATIO)-1:0] phase_cnt,
    output logic                          phase_last,
    output logic                          phase_lock,
    output logic                          phase_err
);

    localparam int PHASE_W = $clog2(pCLK_RATIO);
    localparam int INTV_W  = $clog2(pCLK_RATIO + 1);
    localparam int GOOD_W  = $clog2(pLOCK_CNT + 1);

    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(pCLK_RATIO - 1);
    localparam logic [PHASE_W-1:0] PHASE_OFF = PHASE_W'(pPHASE_OFFSET);
    localparam logic [INTV_W-1:0]  INTV_GOOD = INTV_W'(pCLK_RATIO - 1);
    localparam logic [INTV_W-1:0]  INTV_SAT  = INTV_W'(pCLK_RATIO);
    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(pLOCK_CNT - 1);

    logic                 sync_out;
    logic                 prev;
    logic                 toggle_edge;
    logic [PHASE_W-1:0]   phase_nxt;
    logic [INTV_W-1:0]    interval;
    logic                 good_edge;
    logic                 bad_edge;
    logic                 timeout;
    phase_trk_state_e     state;
    phase_trk_state_e     state_nxt;
    logic [GOOD_W-1:0]    good_cnt;
    logic [GOOD_W-1:0]    good_nxt;
    logic                 err_nxt;

    fsic_bit_sync #(
        .pSTAGES (pSYNC_STAGES)
    ) u_toggle_sync (
        .clk (ioclk),
        .rst (axis_rst),
        .d   (core_clk_toggle),
        .q   (sync_out)
    );

    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_out;
        end
    end

    assign toggle_edge = sync_out ^ prev;

    // Ratio need not be a power of two, so the wrap is an explicit compare.
    always_comb begin
        phase_nxt = phase_cnt + 1'b1;
        if (toggle_edge) begin
            phase_nxt = PHASE_OFF;
        end else if (phase_cnt == PHASE_MAX) begin
            phase_nxt = '0;
        end
    end

    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            phase_cnt  <= '0;
            phase_last <= 1'b0;
        end else begin
            phase_cnt  <= phase_nxt;
            phase_last <= (phase_nxt == PHASE_MAX);
        end
    end

    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            interval <= '0;
        end else if (toggle_edge) begin
            interval <= '0;
        end else if (interval != INTV_SAT) begin
            interval <= interval + 1'b1;
        end
    end

    // Timeout fires only on the step into saturation, so a long gap reports once.
    assign good_edge = toggle_edge && (interval == INTV_GOOD);
    assign bad_edge  = toggle_edge && (interval != INTV_GOOD);
    assign timeout   = !toggle_edge && (interval == INTV_GOOD);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = 1'b0;
        case (state)
            UNLOCK: begin
                if (toggle_edge) begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
            end
            ACQ: begin
                if (good_edge) begin
                    if (good_cnt == GOOD_LAST) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + 1'b1;
                    end
                end else if (bad_edge) begin
                    good_nxt = '0;
                end else if (timeout) begin
                    state_nxt = UNLOCK;
                end
            end
            LOCKED: begin
                if (bad_edge) begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                    err_nxt   = 1'b1;
                end else if (timeout) begin
                    state_nxt = UNLOCK;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = UNLOCK;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            state     <= UNLOCK;
            good_cnt  <= '0;
            phase_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            phase_err <= err_nxt;
        end
    end

    assign phase_lock = (state == LOCKED);

`ifdef FSIC_PHASE_TRK_ERR_CNT_EN
    // Clear wins over a coincident error so software never loses the reset.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_nxt && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
